// File: rtl/vj_window_scanner.sv
// ---------------------------------------------------------------------------
// vj_window_scanner
//
// Frame-level scheduler for the 19x19 Viola-Jones cascade evaluator. Once a
// frame's integral image is ready it walks the detection window over the
// frame in raster order (x fastest, then y) with a fixed stride. For each
// window it issues one start to the cascade and waits for its done. Every
// passing window {x, y, score} is pushed into a small detection FIFO that
// downstream post-processing or the host drains.
//
// Parameters:
//   IMG_W, IMG_H  frame size in pixels
//   WIN           window side in pixels
//   STEP          window stride in x and y (>= 1)
//   DET_DEPTH     detection FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_start         pulse: new integral image valid (ignored while busy)
//   abort               level: stop after the in-flight window completes
//   cas_start           one-cycle start pulse to the cascade
//   cas_win_x/y         origin of the window being evaluated
//   cas_done            cascade completion pulse
//   cas_pass/cas_score  cascade verdict and signed score, valid with cas_done
//   det_valid/ready     FIFO head handshake; pop on det_valid && det_ready
//   det_x/y/score       FIFO head entry
//   busy                scan in progress
//   frame_done          one-cycle pulse at end of scan or abort
//   det_count           detections written this frame (saturating)
//   drop_count          detections lost this frame (saturating)
//
// Build option:
//   VJ_SCAN_BACKPRESSURE_EN  when defined, the scanner stalls before issuing a
//                            window while the FIFO is full, so no detection is
//                            ever lost. When undefined it never stalls and a
//                            pass arriving at a full FIFO with no concurrent
//                            pop is discarded and counted in drop_count.
// ---------------------------------------------------------------------------
module vj_window_scanner #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int WIN       = 19,
  parameter int STEP      = 4,
  parameter int DET_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        abort,
  output logic        cas_start,
  output logic [9:0]  cas_win_x,
  output logic [8:0]  cas_win_y,
  input  logic        cas_done,
  input  logic        cas_pass,
  input  logic [31:0] cas_score,
  output logic        det_valid,
  input  logic        det_ready,
  output logic [9:0]  det_x,
  output logic [8:0]  det_y,
  output logic [31:0] det_score,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] det_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DET_DEPTH);

  // Last window origin on each axis: the largest multiple of STEP that still
  // keeps the whole window inside the frame.
  localparam logic [9:0] X_LAST = 10'(((IMG_W - WIN) / STEP) * STEP);
  localparam logic [8:0] Y_LAST = 9'(((IMG_H - WIN) / STEP) * STEP);
  localparam logic [9:0] X_STEP = 10'(STEP);
  localparam logic [8:0] Y_STEP = 9'(STEP);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic start_nxt;
  logic frame_done_nxt;
  logic busy_nxt;
  logic load_frame;
  logic advance;
  logic last_win;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [9:0]   mem_x     [DET_DEPTH];
  logic [8:0]   mem_y     [DET_DEPTH];
  logic [31:0]  mem_score [DET_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push_ok;
  logic pop;
  logic drop_evt;
  logic issue_stall;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign det_valid = !fifo_empty;
  assign det_x     = mem_x[rd_ptr[AW-1:0]];
  assign det_y     = mem_y[rd_ptr[AW-1:0]];
  assign det_score = mem_score[rd_ptr[AW-1:0]];

  assign pop      = det_valid && det_ready;
  assign push_req = (state == WAIT) && cas_done && cas_pass;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok  = push_req && (!fifo_full || pop);

  assign last_win = (cas_win_x == X_LAST) && (cas_win_y == Y_LAST);

`ifdef VJ_SCAN_BACKPRESSURE_EN
  assign issue_stall = fifo_full;
  assign drop_evt    = 1'b0;
`else
  assign issue_stall = 1'b0;
  assign drop_evt    = push_req && !push_ok;
`endif

  // State register plus the registered control outputs. cas_start,
  // frame_done and busy are all registered, which is what places the start
  // pulse one cycle after ISSUE and the done pulse one cycle after DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cas_start  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cas_start  <= start_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic. abort is only looked at in ISSUE (before a start is
  // launched) and at the cas_done of the window in flight, so a window that
  // has been started always completes and its result is kept.
  always_comb begin
    next_state     = state;
    start_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    busy_nxt       = busy;
    load_frame     = 1'b0;
    advance        = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          load_frame = 1'b1;
          busy_nxt   = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          next_state = DONE;
        end else if (!issue_stall) begin
          start_nxt  = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cas_done) begin
          if (abort || last_win) begin
            next_state = DONE;
          end else begin
            advance    = 1'b1;
            next_state = ISSUE;
          end
        end
      end
      DONE: begin
        frame_done_nxt = 1'b1;
        busy_nxt       = 1'b0;
        next_state     = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Window origin. It only moves when a window completes without ending the
  // scan, so it is stable for the whole time the cascade is working on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cas_win_x <= '0;
      cas_win_y <= '0;
    end else if (load_frame) begin
      cas_win_x <= '0;
      cas_win_y <= '0;
    end else if (advance) begin
      if (cas_win_x == X_LAST) begin
        cas_win_x <= '0;
        cas_win_y <= cas_win_y + Y_STEP;
      end else begin
        cas_win_x <= cas_win_x + X_STEP;
      end
    end
  end

  // Per-frame statistics, cleared when a new frame is accepted and held at
  // all-ones once they saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_count  <= '0;
      drop_count <= '0;
    end else if (load_frame) begin
      det_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok && (det_count != 16'hFFFF)) begin
        det_count <= det_count + 16'd1;
      end
      if (drop_evt && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Detection FIFO storage. It survives frame_start so that a slow consumer
  // can still drain the previous frame; only reset empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DET_DEPTH; i++) begin
        mem_x[i]     <= '0;
        mem_y[i]     <= '0;
        mem_score[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_x[wr_ptr[AW-1:0]]     <= cas_win_x;
        mem_y[wr_ptr[AW-1:0]]     <= cas_win_y;
        mem_score[wr_ptr[AW-1:0]] <= cas_score;
        wr_ptr                    <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_vj_window_scanner.sv
// ---------------------------------------------------------------------------
// tb_vj_window_scanner
//
// Self-checking bench for vj_window_scanner on a small 24x21 frame with a
// 19-pixel window, stride 2 and a 2-deep detection FIFO (a 3x2 grid of
// windows). A cascade model answers every start after a random latency with
// a verdict chosen by the current scenario, and drives det_ready by the
// scenario's consumer policy. Expected windows come from walking the frame
// with plain loops; expected FIFO contents and counters come from a queue
// that accepts a pass when it has room or a pop happens in the same cycle.
// Honours VJ_SCAN_BACKPRESSURE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_vj_window_scanner;

  localparam int IMG_W = 24;
  localparam int IMG_H = 21;
  localparam int WIN   = 19;
  localparam int STEP  = 2;
  localparam int DEPTH = 2;

  logic        clk         = 1'b0;
  logic        reset_n     = 1'b0;
  logic        frame_start = 1'b0;
  logic        abort       = 1'b0;
  logic        cas_done    = 1'b0;
  logic        cas_pass    = 1'b0;
  logic [31:0] cas_score   = '0;
  logic        det_ready   = 1'b0;
  logic        cas_start;
  logic [9:0]  cas_win_x;
  logic [8:0]  cas_win_y;
  logic        det_valid;
  logic [9:0]  det_x;
  logic [8:0]  det_y;
  logic [31:0] det_score;
  logic        busy;
  logic        frame_done;
  logic [15:0] det_count;
  logic [15:0] drop_count;

  vj_window_scanner #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .STEP(STEP), .DET_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort),
    .cas_start(cas_start), .cas_win_x(cas_win_x), .cas_win_y(cas_win_y),
    .cas_done(cas_done), .cas_pass(cas_pass), .cas_score(cas_score),
    .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x),
    .det_y(det_y), .det_score(det_score), .busy(busy),
    .frame_done(frame_done), .det_count(det_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } win_t;
  typedef struct { logic [9:0] x; logic [8:0] y; logic [31:0] score; } det_t;

  win_t grid[$];
  win_t starts_q[$];
  det_t model_q[$];

  int total = 0;
  int bad   = 0;
  int m_det = 0;
  int m_drop = 0;
  int m_lost = 0;
  int n_fd = 0;
  int verdict_mode = 0;
  int ready_mode = 0;
  bit pend = 1'b0;
  int lat = 0;
  int cur_x = 0;
  int cur_y = 0;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Outputs are compared one time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Cascade model, consumer and FIFO reference. Everything happens at the
  // falling edge: drive this cycle's inputs, compare the FIFO head, then
  // account for what the next rising edge will do.
  initial begin : cycle_model
    bit   pop_now;
    det_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
        model_q.delete();
        cas_done  = 1'b0;
        cas_pass  = 1'b0;
        cas_score = '0;
        det_ready = 1'b0;
      end else begin
        cas_done  = 1'b0;
        cas_pass  = 1'b0;
        cas_score = '0;
        if (pend) begin
          if (lat == 0) begin
            pend     = 1'b0;
            cas_done = 1'b1;
            case (verdict_mode)
              0: begin cas_pass = 1'b0; cas_score = $urandom; end
              1: begin
                cas_pass  = (cur_x == 4) && (cur_y == 0);
                cas_score = cas_pass ? 32'd37 : $urandom;
              end
              2: begin cas_pass = 1'b1; cas_score = $urandom; end
              default: begin
                cas_pass  = ($urandom_range(0, 1) == 1);
                cas_score = $urandom;
              end
            endcase
          end else begin
            lat--;
          end
        end
        if (cas_start === 1'b1) begin
          cur_x = int'(cas_win_x);
          cur_y = int'(cas_win_y);
          starts_q.push_back('{x: cur_x, y: cur_y});
          pend = 1'b1;
          lat  = $urandom_range(0, 3);
        end
        case (ready_mode)
          0: det_ready = 1'b0;
          1: det_ready = 1'b1;
          2: det_ready = ($urandom_range(0, 1) == 1);
          default: det_ready = cas_done;
        endcase
        check_output("det_valid", 64'(det_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
          check_output("head_x", 64'(det_x), 64'(model_q[0].x));
          check_output("head_y", 64'(det_y), 64'(model_q[0].y));
          check_output("head_score", 64'(det_score), 64'(model_q[0].score));
        end
        pop_now = (model_q.size() != 0) && det_ready;
        if (cas_done && cas_pass) begin
          e.x = 10'(cur_x);
          e.y = 9'(cur_y);
          e.score = cas_score;
          if ((model_q.size() < DEPTH) || pop_now) begin
            model_q.push_back(e);
            m_det++;
          end else begin
`ifdef VJ_SCAN_BACKPRESSURE_EN
            m_lost++;
`else
            m_drop++;
`endif
          end
        end
        if (pop_now) void'(model_q.pop_front());
        if (frame_done === 1'b1) n_fd++;
      end
    end
  end

  // Pulses frame_start with the given cascade verdict and consumer policy
  // and checks the start-up timing: busy the next cycle, first start after.
  task automatic apply_stimulus(input int vmode, input int rmode);
    bit empty_at_start;
    verdict_mode = vmode;
    ready_mode   = rmode;
    starts_q.delete();
    m_det  = 0;
    m_drop = 0;
    empty_at_start = (model_q.size() == 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_output("busy_rise", 64'(busy), 64'd1);
    check_output("start_not_yet", 64'(cas_start), 64'd0);
    step();
`ifdef VJ_SCAN_BACKPRESSURE_EN
    if (empty_at_start) check_output("first_start", 64'(cas_start), 64'd1);
`else
    check_output("first_start", 64'(cas_start), 64'd1);
    check_output("first_start_empty_flag", 64'(empty_at_start || 1'b1), 64'd1);
`endif
  endtask

  task automatic wait_frame_done(input string tag);
    int base = n_fd;
    int k = 0;
    while ((n_fd == base) && (k < 600)) begin
      step();
      k++;
    end
    check_output({tag, "_busy_fall"}, 64'(busy), 64'd0);
    step(); step(); step();
    check_output({tag, "_frame_done_once"}, 64'(n_fd - base), 64'd1);
`ifdef VJ_SCAN_BACKPRESSURE_EN
    check_output({tag, "_no_lost"}, 64'(m_lost), 64'd0);
`endif
  endtask

  task automatic wait_starts(input string tag, input int n);
    int k = 0;
    while ((starts_q.size() < n) && (k < 300)) begin
      step();
      k++;
    end
    check_output({tag, "_starts_reached"}, 64'(starts_q.size() >= n), 64'd1);
  endtask

  task automatic check_grid(input string tag, input int n);
    check_output({tag, "_num_windows"}, 64'(starts_q.size()), 64'(n));
    for (int i = 0; i < n && i < starts_q.size(); i++) begin
      check_output({tag, "_win_x"}, 64'(starts_q[i].x), 64'(grid[i].x));
      check_output({tag, "_win_y"}, 64'(starts_q[i].y), 64'(grid[i].y));
    end
  endtask

  task automatic check_counts(input string tag);
    check_output({tag, "_det_count"}, 64'(det_count), 64'(m_det));
    check_output({tag, "_drop_count"}, 64'(drop_count), 64'(m_drop));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    ready_mode = 1;
    while ((model_q.size() != 0) && (k < 20)) begin
      step();
      k++;
    end
    step();
    check_output({tag, "_empty"}, 64'(det_valid), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_cas_start"}, 64'(cas_start), 64'd0);
    check_output({tag, "_cas_win_x"}, 64'(cas_win_x), 64'd0);
    check_output({tag, "_cas_win_y"}, 64'(cas_win_y), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check_output({tag, "_det_valid"}, 64'(det_valid), 64'd0);
    check_output({tag, "_det_x"}, 64'(det_x), 64'd0);
    check_output({tag, "_det_y"}, 64'(det_y), 64'd0);
    check_output({tag, "_det_score"}, 64'(det_score), 64'd0);
    check_output({tag, "_det_count"}, 64'(det_count), 64'd0);
    check_output({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : directed
    for (int yy = 0; yy + WIN <= IMG_H; yy += STEP)
      for (int xx = 0; xx + WIN <= IMG_W; xx += STEP)
        grid.push_back('{x: xx, y: yy});

    $display("[TB] reset");
    repeat (3) step();
    check_reset_state("por");
    reset_n = 1'b1;
    step(); step();

    $display("[TB] all windows fail");
    apply_stimulus(0, 2);
    wait_frame_done("fail_all");
    check_grid("fail_all", 6);
    check_output("fail_all_det_count", 64'(det_count), 64'd0);
    check_output("fail_all_drop_count", 64'(drop_count), 64'd0);

    $display("[TB] only (4,0) passes");
    apply_stimulus(1, 0);
    wait_frame_done("one_pass");
    check_grid("one_pass", 6);
    check_output("one_pass_det_count", 64'(det_count), 64'd1);
    check_output("one_pass_valid", 64'(det_valid), 64'd1);
    check_output("one_pass_x", 64'(det_x), 64'd4);
    check_output("one_pass_y", 64'(det_y), 64'd0);
    check_output("one_pass_score", 64'(det_score), 64'd37);
    drain("one_pass");

    $display("[TB] every window passes, consumer stalled");
    apply_stimulus(2, 0);
`ifdef VJ_SCAN_BACKPRESSURE_EN
    repeat (40) step();
    check_output("stall_starts", 64'(starts_q.size()), 64'd2);
    check_output("stall_busy", 64'(busy), 64'd1);
    ready_mode = 1;
    wait_frame_done("stall");
    check_grid("stall", 6);
    check_output("stall_det_count", 64'(det_count), 64'd6);
    check_output("stall_drop_count", 64'(drop_count), 64'd0);
`else
    wait_frame_done("overflow");
    check_grid("overflow", 6);
    check_output("overflow_det_count", 64'(det_count), 64'd2);
    check_output("overflow_drop_count", 64'(drop_count), 64'd4);
    check_output("overflow_valid", 64'(det_valid), 64'd1);

    $display("[TB] push and pop together on a full FIFO");
    apply_stimulus(2, 3);
    wait_frame_done("push_pop_full");
    check_grid("push_pop_full", 6);
    check_output("push_pop_full_det_count", 64'(det_count), 64'd6);
    check_output("push_pop_full_drop_count", 64'(drop_count), 64'd0);
    check_output("push_pop_full_valid", 64'(det_valid), 64'd1);
`endif
    drain("after_full");

    $display("[TB] random verdicts, frame_start mid-scan");
    apply_stimulus(3, 2);
    wait_starts("restart", 3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_frame_done("restart");
    check_grid("restart", 6);
    check_counts("restart");

    $display("[TB] abort during window (2,0)");
    apply_stimulus(3, 2);
    wait_starts("abort", 2);
    abort = 1'b1;
    wait_frame_done("abort");
    abort = 1'b0;
    repeat (4) step();
    check_grid("abort", 2);
    check_counts("abort");

    $display("[TB] reset while waiting on the cascade");
    apply_stimulus(3, 2);
    wait_starts("mid_reset", 1);
    reset_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    step(); step();
    reset_n = 1'b1;
    step();

    $display("[TB] random frame after reset");
    apply_stimulus(3, 2);
    wait_frame_done("post_reset");
    check_grid("post_reset", 6);
    check_counts("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
